// File: rtl/ehl_cell_bist.sv
`default_nettype none
// ============================================================================
// Module   : ehl_cell_bist
// Brief    : BIST controller driving an RTL cell and its technology-mapped
//            twin with LFSR vectors and counting response mismatches.
//            Define EHL_BIST_WALKING_EN for a walking-one phase before RUN.
// Revision : 1.0
// ============================================================================
module ehl_cell_bist #(
    parameter int          WIDTH        = 8,
    parameter int          LATENCY      = 1,
    parameter int          NUM_VECTORS  = 256,
    parameter int          RESET_CYCLES = 8,
    parameter int          CNT_WIDTH    = 16,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 dut_reset_n,
    output logic [WIDTH-1:0]     stim,
    input  logic [WIDTH-1:0]     resp_ref,
    input  logic [WIDTH-1:0]     resp_map,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] first_err_idx
);

    localparam logic [15:0] c_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] c_TAPS = 16'hB400;
    localparam int c_MAX_A = (RESET_CYCLES > NUM_VECTORS) ? RESET_CYCLES : NUM_VECTORS;
    localparam int c_MAX_B = (WIDTH > LATENCY) ? WIDTH : LATENCY;
    localparam int c_MAXC  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_SW    = $clog2(c_MAXC + 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_HOLD  = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
`ifdef EHL_BIST_WALKING_EN
    localparam logic [2:0] c_ST_WALK  = 3'd5;
`endif

    logic [2:0]                          r_state;
    logic [c_SW-1:0]                     r_step;
    logic [15:0]                         r_lfsr;
    logic [CNT_WIDTH-1:0]                r_idx;
    logic [LATENCY-1:0]                  r_pipe_vld;
    logic [LATENCY-1:0][CNT_WIDTH-1:0]   r_pipe_idx;

    logic [15:0]                         w_lfsr_next;
    logic                                w_hold_last;
    logic                                w_push;
    logic                                w_mismatch;
    logic [CNT_WIDTH-1:0]                w_cmp_idx;
    logic [CNT_WIDTH-1:0]                w_err_next;
    logic [CNT_WIDTH-1:0]                w_first_next;
    logic [LATENCY:0]                    w_vld_chain;
    logic [LATENCY:0][CNT_WIDTH-1:0]     w_idx_chain;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_TAPS : 16'h0000);
    assign w_hold_last = (r_state == c_ST_HOLD) && (r_step == c_SW'(RESET_CYCLES - 1));
`ifdef EHL_BIST_WALKING_EN
    assign w_push      = (r_state == c_ST_RUN) || (r_state == c_ST_WALK);
`else
    assign w_push      = (r_state == c_ST_RUN);
`endif

    // The under-reset check shares the comparator; the pipeline is empty then.
    assign w_cmp_idx   = w_hold_last ? '0 : r_pipe_idx[LATENCY-1];
    assign w_mismatch  = (w_hold_last || r_pipe_vld[LATENCY-1]) && (resp_ref != resp_map);
    assign w_vld_chain = {r_pipe_vld, w_push};
    assign w_idx_chain = {r_pipe_idx, r_idx};

    always_comb begin
        w_err_next   = err_cnt;
        w_first_next = first_err_idx;
        if (w_mismatch) begin
            if (err_cnt != '1)
                w_err_next = err_cnt + CNT_WIDTH'(1);
            if (first_err_idx == '1)
                w_first_next = w_cmp_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_ST_IDLE;
            r_step        <= '0;
            r_lfsr        <= c_SEED;
            r_idx         <= '0;
            r_pipe_vld    <= '0;
            r_pipe_idx    <= '0;
            dut_reset_n   <= 1'b0;
            stim          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '1;
        end else begin
            r_pipe_vld    <= w_vld_chain[LATENCY-1:0];
            r_pipe_idx    <= w_idx_chain[LATENCY-1:0];
            err_cnt       <= w_err_next;
            first_err_idx <= w_first_next;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state       <= c_ST_HOLD;
                        r_step        <= '0;
                        r_lfsr        <= c_SEED;
                        r_idx         <= '0;
                        dut_reset_n   <= 1'b0;
                        stim          <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_cnt       <= '0;
                        first_err_idx <= '1;
                    end
                end
                c_ST_HOLD: begin
                    r_step <= r_step + c_SW'(1);
                    if (w_hold_last) begin
                        r_step      <= '0;
                        dut_reset_n <= 1'b1;
`ifdef EHL_BIST_WALKING_EN
                        r_state     <= c_ST_WALK;
`else
                        r_state     <= c_ST_RUN;
`endif
                    end
                end
`ifdef EHL_BIST_WALKING_EN
                c_ST_WALK: begin
                    stim   <= WIDTH'(1) << r_step;
                    r_idx  <= r_idx + CNT_WIDTH'(1);
                    r_step <= r_step + c_SW'(1);
                    if (r_step == c_SW'(WIDTH - 1)) begin
                        r_step  <= '0;
                        r_state <= c_ST_RUN;
                    end
                end
`endif
                c_ST_RUN: begin
                    stim   <= r_lfsr[WIDTH-1:0];
                    r_lfsr <= w_lfsr_next;
                    r_idx  <= r_idx + CNT_WIDTH'(1);
                    r_step <= r_step + c_SW'(1);
                    if (r_step == c_SW'(NUM_VECTORS - 1)) begin
                        r_step  <= '0;
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    r_step <= r_step + c_SW'(1);
                    if (r_step == c_SW'(LATENCY - 1)) begin
                        r_step  <= '0;
                        r_state <= c_ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ehl_cell_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ehl_cell_bist
// Brief    : Self-checking bench for ehl_cell_bist against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_ehl_cell_bist;

    localparam int W  = 8;
    localparam int L  = 1;
    localparam int NV = 256;
    localparam int R  = 8;
`ifdef EHL_BIST_WALKING_EN
    localparam int P  = W;
`else
    localparam int P  = 0;
`endif
    localparam int V  = P + NV;
    localparam int T_DONE = R + V + L;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        sat_start = 1'b0;

    logic        dut_reset_n, busy, done, pass;
    logic [7:0]  stim, resp_ref, resp_map;
    logic [15:0] err_cnt, first_err_idx;

    logic        s_dut_reset_n, s_busy, s_done, s_pass;
    logic [3:0]  s_stim, s_resp_ref, s_resp_map, s_err_cnt, s_first_err_idx;
    logic [3:0]  s_cell_q;

    int          checks = 0;
    int          errors = 0;

    // Model state: cycles since the accepted start edge, error bookkeeping.
    bit          m_started = 1'b0;
    int          m_n = -1;
    logic [15:0] m_err = '0;
    logic [15:0] m_first = 16'hFFFF;
    int          inj_j = -1;
    bit          corrupt_q = 1'b0;
    bit          chk_en = 1'b0;
    logic [7:0]  vec [V];

    always #5 clk = ~clk;

    ehl_cell_bist u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .dut_reset_n(dut_reset_n), .stim(stim),
        .resp_ref(resp_ref), .resp_map(resp_map),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx)
    );

    ehl_cell_bist #(
        .WIDTH(4), .LATENCY(2), .NUM_VECTORS(20), .RESET_CYCLES(3), .CNT_WIDTH(4)
    ) u_sat (
        .clk(clk), .reset_n(reset_n), .start(sat_start),
        .dut_reset_n(s_dut_reset_n), .stim(s_stim),
        .resp_ref(s_resp_ref), .resp_map(s_resp_map),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_cnt(s_err_cnt), .first_err_idx(s_first_err_idx)
    );

    // Cells: combinational copy for the main DUT, one register for the L=2 one.
    assign resp_ref = stim;
    assign resp_map = resp_ref ^ {7'b0, corrupt_q};
    always @(posedge clk) s_cell_q <= s_stim;
    assign s_resp_ref = s_cell_q;
    assign s_resp_map = ~s_cell_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (n=%0d t=%0t)", name, act, exp, m_n, $time);
        end
    endtask

    task automatic wait_n(input int target);
        int k = 0;
        while (m_n != target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (m_n != target) begin
            errors++;
            $display("FAIL wait_n got n=%0d expected n=%0d", m_n, target);
        end
    endtask

    always @(negedge clk)
        corrupt_q <= m_started && (inj_j >= 0) && (m_n == R + inj_j + L);

    always @(posedge clk) begin
        if (!reset_n) begin
            m_started = 1'b0;
            m_n       = -1;
            m_err     = '0;
            m_first   = 16'hFFFF;
        end else if (start && (!m_started || m_n >= T_DONE)) begin
            m_started = 1'b1;
            m_n       = 0;
            m_err     = '0;
            m_first   = 16'hFFFF;
        end else if (m_started) begin
            if (corrupt_q && (m_n == R - 1 || (m_n >= R + L && m_n <= R + V - 1 + L))) begin
                if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                if (m_first == 16'hFFFF) m_first = (m_n == R - 1) ? 16'd0 : 16'(m_n - R - L);
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        logic       e_rst, e_busy, e_done;
        logic [7:0] e_stim;
        int         j;
        if (chk_en) begin
            if (!m_started) begin
                e_rst = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_stim = '0;
            end else begin
                e_rst  = (m_n >= R);
                e_busy = (m_n < T_DONE);
                e_done = !e_busy;
                j      = m_n - R - 1;
                if (j > V - 1) j = V - 1;
                e_stim = (m_n <= R) ? 8'h00 : vec[j];
            end
            check("dut_reset_n", 32'(dut_reset_n), 32'(e_rst));
            check("stim", 32'(stim), 32'(e_stim));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("pass", 32'(pass), 32'(e_done && m_err == 16'd0));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
            check("first_err_idx", 32'(first_err_idx), 32'(m_first));
        end
    end

    initial begin
        logic [15:0] l;
        logic [7:0]  walk_tab [8];
        int          busy_cycles;
        int          guard;
        walk_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        l = 16'hACE1;
        for (int j = 0; j < V; j++) begin
            if (j < P) begin
                vec[j] = 8'h01 << j;
            end else begin
                vec[j] = l[7:0];
                l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            end
        end

        // Reset state
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dut_reset_n", 32'(dut_reset_n), 32'd0);
        check("rst_first_err_idx", 32'(first_err_idx), 32'hFFFF);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean run with a stray start mid-RUN; saturation instance runs alongside.
        start = 1'b1; sat_start = 1'b1;
        @(negedge clk);
        start = 1'b0; sat_start = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (m_n < T_DONE && guard < 3000) begin
            if (busy) busy_cycles++;
            start = (m_n == R + 50);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
`ifdef EHL_BIST_WALKING_EN
        check("busy_cycles", 32'(busy_cycles), 32'd273);
`else
        check("busy_cycles", 32'(busy_cycles), 32'd265);
`endif
        check("A_done", 32'(done), 32'd1);
        check("A_pass", 32'(pass), 32'd1);
        check("A_err_cnt", 32'(err_cnt), 32'd0);
        check("A_first_err_idx", 32'(first_err_idx), 32'hFFFF);
        check("sat_done", 32'(s_done), 32'd1);
        check("sat_err_cnt", 32'(s_err_cnt), 32'hF);
        check("sat_first_err_idx", 32'(s_first_err_idx), 32'd0);
        check("sat_pass", 32'(s_pass), 32'd0);

        // Restart from DONE with a single-bit fault on vector 37.
        inj_j = 37;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_n(R + P + 1);
        check("B_first_run_stim", 32'(stim), 32'hE1);
        @(negedge clk);
        check("B_second_run_stim", 32'(stim), 32'h70);
        wait_n(T_DONE);
        check("B_err_cnt", 32'(err_cnt), 32'd1);
        check("B_first_err_idx", 32'(first_err_idx), 32'd37);
        check("B_pass", 32'(pass), 32'd0);
        inj_j = -1;

        // Reset pulse at vector 100 aborts, then a full run passes.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_n(R + 1 + 100);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("C_dut_reset_n", 32'(dut_reset_n), 32'd0);
        check("C_err_cnt", 32'(err_cnt), 32'd0);
        check("C_done", 32'(done), 32'd0);
        check("C_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_n(T_DONE);
        check("C_pass", 32'(pass), 32'd1);
        check("C_err_cnt_final", 32'(err_cnt), 32'd0);

`ifdef EHL_BIST_WALKING_EN
        inj_j = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_n(R + 1 + k);
            check("D_walk_stim", 32'(stim), 32'(walk_tab[k]));
        end
        wait_n(R + 1 + 8);
        check("D_first_lfsr_stim", 32'(stim), 32'hE1);
        wait_n(T_DONE);
        check("D_first_err_idx", 32'(first_err_idx), 32'd3);
        check("D_err_cnt", 32'(err_cnt), 32'd1);
        inj_j = -1;
`else
        check("D_walk_unused", 32'(walk_tab[0]) & 32'(stim) & 32'h0, 32'h0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
